vtdl_fifo: RTL and testbench

Shift-register FIFO built on a variable-tap delay line: writes shift data into a non-reset storage array, and the read tap tracks the occupancy level so the oldest entry always appears at the output (first-word fall-through). It is the parametrised successor to the plain delay line, adding occupancy tracking, full/empty/almost-full flags, flush and sticky error reporting. It sits in rate-control paths (instruction queues, bus-response buffering) where small, LUT-friendly FIFOs are needed.

---
 rtl/vtdl_pkg.sv | 15 +
 rtl/vtdl_fifo_if.sv | 33 +++
 rtl/vtdl_mem.sv | 38 +++
 rtl/vtdl_fifo.sv | 99 +++++++++
 tb/tb_vtdl_fifo.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/vtdl_pkg.sv
// Width helpers shared by the variable-tap delay line and the FIFO built on it.
// Purely constant functions; no state.
package vtdl_pkg;

    // Bits needed to hold the value dep (an occupancy count of 0..dep).
    function automatic int lvl_w(input int dep);
        return $clog2(dep + 1);
    endfunction

    // Bits needed to address taps 0..dep-1; never narrower than one bit.
    function automatic int addr_w(input int dep);
        return (dep < 2) ? 1 : $clog2(dep);
    endfunction

endpackage

// File: rtl/vtdl_fifo_if.sv
// Data, strobe and status bundle between a vtdl_fifo and its user.
// master drives write/read/flush; slave is the FIFO side.
interface vtdl_fifo_if
    import vtdl_pkg::*;
#(
    parameter int WID = 8,
    parameter int DEP = 16
);
    localparam int LW = lvl_w(DEP);

    logic           clr;
    logic           wr;
    logic [WID-1:0] din;
    logic           rd;
    logic [WID-1:0] dout;
    logic           empty;
    logic           full;
    logic           afull;
    logic [LW-1:0]  level;
    logic           ovf;
    logic           udf;

    modport master (
        output clr, wr, din, rd,
        input  dout, empty, full, afull, level, ovf, udf
    );

    modport slave (
        input  clr, wr, din, rd,
        output dout, empty, full, afull, level, ovf, udf
    );

endinterface

// File: rtl/vtdl_mem.sv
// Variable-tap delay line: shifts d in on ce, q is the combinational tap m[a].
// No reset on the array so it maps onto shift-register LUTs.
module vtdl_mem
    import vtdl_pkg::*;
#(
    parameter int WID = 8,
    parameter int DEP = 16,
    parameter int AW  = addr_w(DEP)
) (
    input  logic           clk,
    input  logic           ce,
    input  logic [AW-1:0]  a,
    input  logic [WID-1:0] d,
    output logic [WID-1:0] q
);

    logic [WID-1:0] m [DEP];

    always_ff @(posedge clk) begin
        if (ce) begin
            for (int n = DEP - 1; n > 0; n--) begin
                m[n] <= m[n-1];
            end
            m[0] <= d;
        end
    end

    // Out-of-range taps only occur for non power-of-two depths; return zero there.
    always_comb begin
        q = '0;
        for (int n = 0; n < DEP; n++) begin
            if (a == AW'(n)) begin
                q = m[n];
            end
        end
    end

endmodule

// File: rtl/vtdl_fifo.sv
// First-word fall-through FIFO on a variable-tap delay line; zero-cycle write-to-dout.
// No backpressure: writes to a full FIFO are dropped (sticky ovf), reads of an empty one flag udf.
module vtdl_fifo
    import vtdl_pkg::*;
#(
    parameter int WID = 8,
    parameter int DEP = 16,
    parameter int AFT = DEP - 2
) (
    input  logic       clk,
    input  logic       rst,
    vtdl_fifo_if.slave bus
);

    localparam int            LW    = lvl_w(DEP);
    localparam int            AW    = addr_w(DEP);
    localparam logic [LW-1:0] DEP_L = LW'(DEP);
    localparam logic [LW-1:0] AFT_L = LW'(AFT);
    localparam logic [LW-1:0] ONE_L = LW'(1);

    logic [LW-1:0]  level_q;
    logic           empty_q;
    logic           full_q;
    logic           afull_q;
    logic           ovf_q;
    logic           udf_q;

    logic           wr_ok;
    logic           rd_ok;
    logic [LW-1:0]  lvl_nx;
    logic [LW-1:0]  lvl_m1;
    logic [AW-1:0]  tap;
    logic [WID-1:0] q;

    // Flush wins over everything; both strobes together at full is a shift-and-pop.
    always_comb begin
        wr_ok  = 1'b0;
        rd_ok  = 1'b0;
        lvl_nx = level_q;
        if (bus.clr) begin
            lvl_nx = '0;
        end else begin
            rd_ok = bus.rd & ~empty_q;
            wr_ok = bus.wr & (~full_q | bus.rd);
            if (wr_ok && !rd_ok) begin
                lvl_nx = level_q + ONE_L;
            end else if (rd_ok && !wr_ok) begin
                lvl_nx = level_q - ONE_L;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            level_q <= lvl_nx;
            empty_q <= (lvl_nx == '0);
            full_q  <= (lvl_nx == DEP_L);
            afull_q <= (lvl_nx >= AFT_L);
            if (bus.wr && full_q && !bus.rd && !bus.clr) begin
                ovf_q <= 1'b1;
            end
            if (bus.rd && empty_q && !bus.clr) begin
                udf_q <= 1'b1;
            end
        end
    end

    // Oldest entry sits level-1 taps deep; the value is don't-care while empty.
    assign lvl_m1 = level_q - ONE_L;
    assign tap    = lvl_m1[AW-1:0];

    vtdl_mem #(
        .WID (WID),
        .DEP (DEP),
        .AW  (AW)
    ) u_mem (
        .clk (clk),
        .ce  (wr_ok),
        .a   (tap),
        .d   (bus.din),
        .q   (q)
    );

    assign bus.dout  = empty_q ? '0 : q;
    assign bus.empty = empty_q;
    assign bus.full  = full_q;
    assign bus.afull = afull_q;
    assign bus.level = level_q;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;

endmodule

// File: tb/tb_vtdl_fifo.sv
// Randomized and directed bench for vtdl_fifo with a queue-based reference model.
// Stimulus pushes the model's expected state after each edge; a monitor compares at the falling edge.
module tb_vtdl_fifo;

    localparam int WID = 8;
    localparam int DEP = 16;
    localparam int AFT = 14;

    logic clk;
    logic rst;

    vtdl_fifo_if #(.WID(WID), .DEP(DEP)) f ();

    vtdl_fifo #(.WID(WID), .DEP(DEP), .AFT(AFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WID-1:0] dout;
        int             level;
        bit             ovf;
        bit             udf;
    } exp_t;

    logic [WID-1:0] mq [$];
    bit             m_ovf;
    bit             m_udf;
    exp_t           eq [$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    // FIFO semantics straight from the rules: pop oldest, append newest, bounded by DEP.
    function automatic void model_apply(input bit w, input bit r, input bit c, input logic [WID-1:0] d);
        int  sz;
        bit  r_ok;
        bit  w_ok;
        if (c) begin
            mq.delete();
            return;
        end
        sz   = mq.size();
        r_ok = r && (sz > 0);
        w_ok = w && ((sz < DEP) || r);
        if (r && sz == 0) m_udf = 1'b1;
        if (w && sz == DEP && !r) m_ovf = 1'b1;
        if (r_ok) void'(mq.pop_front());
        if (w_ok) mq.push_back(d);
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.dout  = (mq.size() > 0) ? mq[0] : '0;
        e.level = mq.size();
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        eq.push_back(e);
    endfunction

    task automatic step(input bit w, input bit r, input bit c, input logic [WID-1:0] d);
        f.wr  = w;
        f.rd  = r;
        f.clr = c;
        f.din = d;
        @(posedge clk);
        model_apply(w, r, c, d);
        push_exp();
        #1;
    endtask

    task automatic chk_now(input string tag);
        chk({tag, " level"}, 32'(f.level), 32'(mq.size()));
        chk({tag, " empty"}, 32'(f.empty), 32'(mq.size() == 0));
        chk({tag, " full"},  32'(f.full),  32'(mq.size() == DEP));
        chk({tag, " afull"}, 32'(f.afull), 32'(mq.size() >= AFT));
        chk({tag, " ovf"},   32'(f.ovf),   32'(m_ovf));
        chk({tag, " udf"},   32'(f.udf),   32'(m_udf));
        chk({tag, " dout"},  32'(f.dout),  32'((mq.size() > 0) ? mq[0] : '0));
    endtask

    // Monitor: every falling edge with a pending expectation compares the full output state.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("dout",  32'(f.dout),  32'(e.dout));
                chk("level", 32'(f.level), 32'(e.level));
                chk("empty", 32'(f.empty), 32'(e.level == 0));
                chk("full",  32'(f.full),  32'(e.level == DEP));
                chk("afull", 32'(f.afull), 32'(e.level >= AFT));
                chk("ovf",   32'(f.ovf),   32'(e.ovf));
                chk("udf",   32'(f.udf),   32'(e.udf));
            end
        end
    end

    initial begin
        int pw;
        int pr;
        f.wr  = 1'b0;
        f.rd  = 1'b0;
        f.clr = 1'b0;
        f.din = '0;
        rst   = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_exp();

        // Basic fall-through ordering
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(1, 0, 0, 8'h33);
        repeat (3) step(0, 1, 0, 8'h00);

        // Fill to full through afull, then a dropped write
        for (int i = 0; i < DEP; i++) step(1, 0, 0, 8'(8'h40 + i));
        step(1, 0, 0, 8'hEE);

        // Shift-and-pop while full, then drain the all-0xAA contents
        repeat (DEP) step(1, 1, 0, 8'hAA);
        repeat (DEP) step(0, 1, 0, 8'h00);

        // Underflow, then simultaneous read/write on empty
        step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h5C);
        step(0, 1, 0, 8'h00);

        // Flush with a concurrent write
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h60 + i));
        step(1, 0, 1, 8'h99);
        step(1, 0, 0, 8'h77);
        step(0, 1, 0, 8'h00);

        // Asynchronous reset at level 9, between edges
        for (int i = 0; i < 9; i++) step(1, 0, 0, 8'(8'h80 + i));
        f.wr = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 chk_now("async_rst");
        #1 rst = 1'b0;
        step(1, 0, 0, 8'h3D);
        step(1, 0, 0, 8'h4E);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);

        // Random phases biased toward filling, draining and balanced traffic
        for (int ph = 0; ph < 12; ph++) begin
            case (ph % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            for (int i = 0; i < 70; i++) begin
                step($urandom_range(99) < pw, $urandom_range(99) < pr,
                     $urandom_range(99) < 2, 8'($urandom));
            end
        end

        step(0, 0, 0, 8'h00);
        @(negedge clk);
        #1 chk("drain", 32'(eq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
